cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_controller.sv | 168 ++++++++++++++++
 tb/tb_cpu_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// cpu_controller: Moore control FSM for a small datapath CPU.
// Sequences register reads, ALU operation, status update and register
// writeback for MOV-imm, MOV-reg, ADD, CMP, AND and MVN instructions.
//
// Handshake: start is a level request sampled only on a rising clk edge
// while waiting=1 (state WAIT). The opcode/ALU_op presented at that edge
// are latched; later changes to start/opcode/ALU_op are ignored until
// waiting returns to 1. Holding start high begins the next instruction on
// the first edge after waiting returns high.
//
// The current state is held in state_q (type state_t) so checkers can bind
// to it directly.
module cpu_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  output logic       waiting,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B
);

  // Instruction classes (opcode field)
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // ALU_op field values within each class
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Decoder register-field selects
  localparam logic [1:0] RSEL_RM = 2'b00;
  localparam logic [1:0] RSEL_RD = 2'b01;
  localparam logic [1:0] RSEL_RN = 2'b10;

  // Writeback sources
  localparam logic [1:0] WB_C      = 2'b00;
  localparam logic [1:0] WB_SXIMM8 = 2'b10;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_ALU    = 3'd5,
    S_STATUS = 3'd6,
    S_WR_RD  = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] opcode_q, opcode_d;
  logic [1:0] op_q, op_d;

  logic       accept;
  logic       is_mov_reg;

  // A new instruction is accepted only while idle.
  assign accept     = (state_q == S_WAIT) && start;
  assign is_mov_reg = (opcode_q == OPC_MOV) && (op_q == OP_MOV_REG);

  // State and latched instruction fields; reset aborts any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_WAIT;
      opcode_q <= 3'b000;
      op_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_q     <= op_d;
    end
  end

  // Capture the decoder fields only on the accepting edge.
  always_comb begin
    opcode_d = opcode_q;
    op_d     = op_q;
    if (accept) begin
      opcode_d = opcode;
      op_d     = ALU_op;
    end
  end

  // Next-state logic; DECODE routes on the latched fields.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (start) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_WAIT;
        if (opcode_q == OPC_MOV) begin
          if (op_q == OP_MOV_IMM)      state_d = S_WR_IMM;
          else if (op_q == OP_MOV_REG) state_d = S_GET_B;
        end else if (opcode_q == OPC_ALU) begin
          if (op_q == OP_MVN) state_d = S_GET_B;
          else                state_d = S_GET_A;
        end
      end
      S_WR_IMM: state_d = S_WAIT;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B: begin
        if ((opcode_q == OPC_ALU) && (op_q == OP_CMP)) state_d = S_STATUS;
        else                                           state_d = S_ALU;
      end
      S_ALU:    state_d = S_WR_RD;
      S_STATUS: state_d = S_WAIT;
      S_WR_RD:  state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  // Moore outputs decoded from the current state and latched fields.
  always_comb begin
    waiting   = 1'b0;
    reg_sel   = RSEL_RM;
    wb_sel    = WB_C;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    case (state_q)
      S_WAIT: waiting = 1'b1;
      S_WR_IMM: begin
        reg_sel = RSEL_RN;
        wb_sel  = WB_SXIMM8;
        w_en    = 1'b1;
      end
      S_GET_A: begin
        reg_sel = RSEL_RN;
        en_A    = 1'b1;
      end
      S_GET_B: begin
        reg_sel = RSEL_RM;
        en_B    = 1'b1;
      end
      S_ALU: begin
        en_C  = 1'b1;
        sel_A = is_mov_reg;
      end
      S_STATUS: en_status = 1'b1;
      S_WR_RD: begin
        reg_sel = RSEL_RD;
        wb_sel  = WB_C;
        w_en    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Testbench for cpu_controller: table of instructions with per-cycle
// expected output words, plus sequences for back-to-back start and
// asynchronous reset mid-instruction.
module tb_cpu_controller;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] ALU_op = 2'b00;
  logic       waiting, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic [1:0] reg_sel, wb_sel;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .ALU_op    (ALU_op),
    .waiting   (waiting),
    .reg_sel   (reg_sel),
    .wb_sel    (wb_sel),
    .w_en      (w_en),
    .en_A      (en_A),
    .en_B      (en_B),
    .en_C      (en_C),
    .en_status (en_status),
    .sel_A     (sel_A),
    .sel_B     (sel_B)
  );

  // Output word: {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B}
  logic [11:0] obs;
  assign obs = {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B};

  localparam logic [11:0] E_WAIT = 12'b1_00_00_0_0000_00;
  localparam logic [11:0] E_DEC  = 12'b0_00_00_0_0000_00;
  localparam logic [11:0] E_WIMM = 12'b0_10_10_1_0000_00;
  localparam logic [11:0] E_GETA = 12'b0_10_00_0_1000_00;
  localparam logic [11:0] E_GETB = 12'b0_00_00_0_0100_00;
  localparam logic [11:0] E_ALU0 = 12'b0_00_00_0_0010_00;
  localparam logic [11:0] E_ALU1 = 12'b0_00_00_0_0010_10;
  localparam logic [11:0] E_STAT = 12'b0_00_00_0_0001_00;
  localparam logic [11:0] E_WRRD = 12'b0_01_00_1_0000_00;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  opc;
    logic [1:0]  op;
    int          len;      // edges from start sample to waiting=1
    logic [11:0] exp [6];  // output word after each edge
    int          wen_n;    // expected number of w_en cycles
    string       name;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic set_vec(input int i, input string nm, input logic [2:0] oc, input logic [1:0] o,
                         input int len, input logic [11:0] e0, input logic [11:0] e1,
                         input logic [11:0] e2, input logic [11:0] e3, input logic [11:0] e4,
                         input logic [11:0] e5, input int wn);
    vecs[i].name = nm;  vecs[i].opc = oc;  vecs[i].op = o;  vecs[i].len = len;
    vecs[i].exp[0] = e0; vecs[i].exp[1] = e1; vecs[i].exp[2] = e2;
    vecs[i].exp[3] = e3; vecs[i].exp[4] = e4; vecs[i].exp[5] = e5;
    vecs[i].wen_n = wn;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from WAIT; inputs are scrambled and start toggled
  // while busy, which must have no effect.
  task automatic run_vec(input int i);
    int wcnt;
    wcnt   = 0;
    opcode = vecs[i].opc;
    ALU_op = vecs[i].op;
    start  = 1'b1;
    for (int k = 0; k < vecs[i].len; k++) begin
      tick();
      check($sformatf("%s_c%0d", vecs[i].name, k + 1), {20'd0, obs}, {20'd0, vecs[i].exp[k]});
      if (w_en) wcnt++;
      opcode = 3'($urandom_range(0, 7));
      ALU_op = 2'($urandom_range(0, 3));
      start  = (k == vecs[i].len - 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    check($sformatf("%s_wen_count", vecs[i].name), wcnt, vecs[i].wen_n);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- test ----------------
  initial begin
    set_vec(0,  "mov_imm", 3'b110, 2'b10, 3, E_DEC, E_WIMM, E_WAIT, 0, 0, 0, 1);
    set_vec(1,  "add",     3'b101, 2'b00, 6, E_DEC, E_GETA, E_GETB, E_ALU0, E_WRRD, E_WAIT, 1);
    set_vec(2,  "and",     3'b101, 2'b10, 6, E_DEC, E_GETA, E_GETB, E_ALU0, E_WRRD, E_WAIT, 1);
    set_vec(3,  "cmp",     3'b101, 2'b01, 5, E_DEC, E_GETA, E_GETB, E_STAT, E_WAIT, 0, 0);
    set_vec(4,  "mov_reg", 3'b110, 2'b00, 5, E_DEC, E_GETB, E_ALU1, E_WRRD, E_WAIT, 0, 1);
    set_vec(5,  "mvn",     3'b101, 2'b11, 5, E_DEC, E_GETB, E_ALU0, E_WRRD, E_WAIT, 0, 1);
    set_vec(6,  "unsup000",3'b000, 2'b00, 2, E_DEC, E_WAIT, 0, 0, 0, 0, 0);
    set_vec(7,  "unsup110_01", 3'b110, 2'b01, 2, E_DEC, E_WAIT, 0, 0, 0, 0, 0);
    set_vec(8,  "unsup110_11", 3'b110, 2'b11, 2, E_DEC, E_WAIT, 0, 0, 0, 0, 0);
    set_vec(9,  "unsup111", 3'b111, 2'b10, 2, E_DEC, E_WAIT, 0, 0, 0, 0, 0);
    set_vec(10, "unsup100", 3'b100, 2'b00, 2, E_DEC, E_WAIT, 0, 0, 0, 0, 0);
    set_vec(11, "add_again", 3'b101, 2'b00, 6, E_DEC, E_GETA, E_GETB, E_ALU0, E_WRRD, E_WAIT, 1);

    // Power-on reset, asserted between edges
    #2 rst_n = 1'b0;
    #1 check("reset_async_out", {20'd0, obs}, {20'd0, E_WAIT});
    tick(); tick();
    check("reset_held_out", {20'd0, obs}, {20'd0, E_WAIT});
    #3 rst_n = 1'b1;
    tick();
    check("reset_idle_out", {20'd0, obs}, {20'd0, E_WAIT});

    // Table-driven instructions
    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-to-back: start held high across the return to WAIT
    opcode = 3'b110; ALU_op = 2'b10; start = 1'b1;
    tick(); check("b2b_c1", {20'd0, obs}, {20'd0, E_DEC});
    tick(); check("b2b_c2", {20'd0, obs}, {20'd0, E_WIMM});
    tick(); check("b2b_c3", {20'd0, obs}, {20'd0, E_WAIT});
    tick(); check("b2b_restart", {20'd0, obs}, {20'd0, E_DEC});
    start = 1'b0;
    tick(); check("b2b_c5", {20'd0, obs}, {20'd0, E_WIMM});
    tick(); check("b2b_c6", {20'd0, obs}, {20'd0, E_WAIT});

    // Reset dropped in GET_B of an ADD, between edges
    opcode = 3'b101; ALU_op = 2'b00; start = 1'b1;
    tick(); start = 1'b0;
    check("rst_mid_dec", {20'd0, obs}, {20'd0, E_DEC});
    tick(); check("rst_mid_geta", {20'd0, obs}, {20'd0, E_GETA});
    tick(); check("rst_mid_getb", {20'd0, obs}, {20'd0, E_GETB});
    #2 rst_n = 1'b0;
    #1 check("rst_mid_async", {20'd0, obs}, {20'd0, E_WAIT});
    tick(); check("rst_mid_held", {20'd0, obs}, {20'd0, E_WAIT});
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rst_after_idle%0d", k), {20'd0, obs}, {20'd0, E_WAIT});
    end
    // Normal operation resumes after reset
    run_vec(0);
    run_vec(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
